// File: rtl/axis_lab_pkg.sv
// rtl/axis_lab_pkg.sv - shared state type and constants for the AXI-Stream lab blocks
package axis_lab_pkg;

  // Sink/source run state.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } lab_state_e;

  localparam logic [15:0] ERR_CNT_MAX = 16'hFFFF;

  // x^16 + x^14 + x^13 + x^11 + 1 as right-shifting Galois taps.
  localparam logic [15:0] LFSR_POLY   = 16'hB400;
  localparam logic [15:0] LFSR_SEED   = 16'hACE1;

endpackage

// File: rtl/axis_lfsr16.sv
// rtl/axis_lfsr16.sv - 16-bit Galois LFSR, advances only while enabled
module axis_lfsr16
  import axis_lab_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  output logic [15:0] state
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  // Next LFSR value: shift right, fold in the taps when a one falls out.
  always_comb begin
    lfsr_d = lfsr_q;
    if (enable) begin
      lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_POLY : 16'h0000);
    end
  end

  // LFSR register, restarts from the shared seed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign state = lfsr_q;

endmodule

// File: rtl/axis_stream_checker.sv
// rtl/axis_stream_checker.sv - AXI-Stream pattern checking sink; AXIS_CHECKER_BACKPRESSURE_EN adds LFSR stalls
module axis_stream_checker
  import axis_lab_pkg::*;
#(
  parameter int                   DATA_SIZE = 32,
  parameter int                   PKT_LEN   = 16,
  parameter logic [DATA_SIZE-1:0] SEED      = '0,
  parameter int                   CNT_WIDTH = 32
) (
  input  logic                   s00_axis_aclk,
  input  logic                   s00_axis_aresetn,
  input  logic                   s00_axis_enable,
  input  logic                   s00_axis_clear,
  input  logic [DATA_SIZE-1:0]   s00_axis_tdata,
  input  logic [DATA_SIZE/8-1:0] s00_axis_tstrb,
  input  logic                   s00_axis_tvalid,
  input  logic                   s00_axis_tlast,
  output logic                   s00_axis_tready,
  output logic [CNT_WIDTH-1:0]   beat_count,
  output logic [CNT_WIDTH-1:0]   pkt_count,
  output logic [15:0]            err_count,
  output logic                   err_flag
);

  localparam int                   STRB_W   = DATA_SIZE / 8;
  localparam int                   IDX_W    = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(PKT_LEN - 1);
  localparam logic [IDX_W-1:0]     IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_SIZE-1:0] DATA_ONE = {{(DATA_SIZE-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  lab_state_e             state_q, state_d;
  logic                   tready_q, tready_d;
  logic [DATA_SIZE-1:0]   exp_q, exp_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [CNT_WIDTH-1:0]   beat_q, beat_d;
  logic [CNT_WIDTH-1:0]   pkt_q, pkt_d;
  logic [15:0]            err_q, err_d;
  logic                   flag_q, flag_d;

  logic                   accept;
  logic                   data_err;
  logic                   last_err;
  logic                   strb_err;
  logic [1:0]             n_err;
  logic [16:0]            err_sum;
  logic                   stall_ok;

`ifdef AXIS_CHECKER_BACKPRESSURE_EN
  logic [15:0] lfsr_state;

  axis_lfsr16 u_lfsr (
    .clk    (s00_axis_aclk),
    .rst_n  (s00_axis_aresetn),
    .enable (state_q == ST_RUN),
    .state  (lfsr_state)
  );

  assign stall_ok = lfsr_state[0];
`else
  assign stall_ok = 1'b1;
`endif

  // Run/idle FSM; tready is produced from registered state only, so the
  // enable input never reaches tready within a cycle.
  always_comb begin
    state_d  = state_q;
    tready_d = 1'b0;
    case (state_q)
      ST_IDLE: if (s00_axis_enable) state_d = ST_RUN;
      ST_RUN:  begin
        if (!s00_axis_enable) state_d = ST_IDLE;
        tready_d = s00_axis_enable & stall_ok;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Per-beat checks run in parallel; clear overrides any coincident beat.
  always_comb begin
    accept   = s00_axis_tvalid & tready_q;
    data_err = (s00_axis_tdata != exp_q);
    last_err = (s00_axis_tlast != (idx_q == IDX_LAST));
    strb_err = (s00_axis_tstrb != {STRB_W{1'b1}});
    n_err    = {1'b0, data_err} + {1'b0, last_err} + {1'b0, strb_err};
    err_sum  = {1'b0, err_q} + {15'd0, n_err};

    exp_d  = exp_q;
    idx_d  = idx_q;
    beat_d = beat_q;
    pkt_d  = pkt_q;
    err_d  = err_q;
    flag_d = flag_q;

    if (s00_axis_clear) begin
      exp_d  = SEED;
      idx_d  = '0;
      beat_d = '0;
      pkt_d  = '0;
      err_d  = '0;
      flag_d = 1'b0;
    end else if (accept) begin
      // Resync to the received data and tlast so one bad beat costs one error.
      exp_d  = s00_axis_tdata + DATA_ONE;
      idx_d  = (s00_axis_tlast || idx_q == IDX_LAST) ? '0 : idx_q + IDX_ONE;
      beat_d = beat_q + CNT_ONE;
      if (s00_axis_tlast) pkt_d = pkt_q + CNT_ONE;
      err_d  = (err_sum > {1'b0, ERR_CNT_MAX}) ? ERR_CNT_MAX : err_sum[15:0];
      if (n_err != 2'd0) flag_d = 1'b1;
    end
  end

  // State, ready and checker registers.
  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      state_q  <= ST_IDLE;
      tready_q <= 1'b0;
      exp_q    <= SEED;
      idx_q    <= '0;
      beat_q   <= '0;
      pkt_q    <= '0;
      err_q    <= '0;
      flag_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tready_q <= tready_d;
      exp_q    <= exp_d;
      idx_q    <= idx_d;
      beat_q   <= beat_d;
      pkt_q    <= pkt_d;
      err_q    <= err_d;
      flag_q   <= flag_d;
    end
  end

  assign s00_axis_tready = tready_q;
  assign beat_count      = beat_q;
  assign pkt_count       = pkt_q;
  assign err_count       = err_q;
  assign err_flag        = flag_q;

endmodule
